// File: rtl/router_local_port_pkg.sv
// ---------------------------------------------------------------------------
// router_local_port_pkg
// Shared definitions for the router local port:
//   - default packet geometry and the packet field offsets
//     (payload in the LSBs, then destination, then source in the MSBs)
//   - output port encodings seen by the crossbar
//   - output FSM state enumeration
// ---------------------------------------------------------------------------
package router_local_port_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 2;

  // Packet layout: {source, destination, payload}.
  localparam int PAYLOAD_LSB = 0;

  function automatic int dest_lsb(input int data_width);
    return PAYLOAD_LSB + data_width;
  endfunction

  function automatic int src_lsb(input int data_width, input int addr_width);
    return PAYLOAD_LSB + data_width + addr_width;
  endfunction

  // Crossbar output port selection.
  typedef enum logic [1:0] {
    PORT_XP = 2'd0,
    PORT_XM = 2'd1,
    PORT_YP = 2'd2,
    PORT_YM = 2'd3
  } port_e;

  // Output (injection toward crossbar) FSM.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/router_local_port_fifo.sv
// ---------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock FIFO holding packets injected by the PE.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset (clears count and pointers)
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : discard head entry (ignored when empty)
//   head_data  : current head entry, valid whenever !empty
//   full/empty : derived from the occupancy count
// The head is read combinationally so the router can compute the route and
// load its output register in the cycle right after a write.
// ---------------------------------------------------------------------------
module noc_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg];

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/router_local_port.sv
// ---------------------------------------------------------------------------
// router_local_port
// Local (PE-facing) port of a 2x2 mesh router with XY routing.
//   clk, rst            : clock; asynchronous active-low reset
//   i_valid_from_pe     : PE offers a packet
//   i_data_from_pe      : packet {src, dest, payload} from PE
//   o_ready_to_pe       : injection FIFO not full
//   o_valid_to_pe       : one-cycle ejection pulse to PE
//   o_data_to_pe        : ejected packet
//   i_valid_from_net    : crossbar delivers a packet for this node
//   i_data_from_net     : packet from crossbar
//   o_valid_to_xbar     : packet offered to crossbar
//   o_data_to_xbar      : offered packet (held until accepted)
//   o_port_sel          : output port 0 X+, 1 X-, 2 Y+, 3 Y-
//   i_ready_from_xbar   : crossbar accepts the offered packet
//   o_err_cnt           : saturating count of packets dropped for bad source
// ---------------------------------------------------------------------------
module router_local_port
  import router_local_port_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] NODE_ADDR  = 2'b01,
  localparam int                   PW         = DATA_WIDTH + 2 * ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid_from_pe,
  input  logic [PW-1:0] i_data_from_pe,
  output logic          o_ready_to_pe,
  output logic          o_valid_to_pe,
  output logic [PW-1:0] o_data_to_pe,
  input  logic          i_valid_from_net,
  input  logic [PW-1:0] i_data_from_net,
  output logic          o_valid_to_xbar,
  output logic [PW-1:0] o_data_to_xbar,
  output logic [1:0]    o_port_sel,
  input  logic          i_ready_from_xbar,
  output logic [7:0]    o_err_cnt
);

  localparam int DEST_LSB = dest_lsb(DATA_WIDTH);
  localparam int SRC_LSB  = src_lsb(DATA_WIDTH, ADDR_WIDTH);
  // Low half of the address is X, high half is Y.
  localparam int XW = (ADDR_WIDTH / 2 > 0) ? ADDR_WIDTH / 2 : 1;
  localparam int YW = (ADDR_WIDTH - XW > 0) ? ADDR_WIDTH - XW : 1;
  localparam logic [XW-1:0] LOCAL_X = NODE_ADDR[XW-1:0];
  localparam logic [YW-1:0] LOCAL_Y = NODE_ADDR[ADDR_WIDTH-1 -: YW];

  // Injection side
  logic                  pe_accept;
  logic                  src_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW-1:0]         fifo_head;

  // Route of the FIFO head
  logic [ADDR_WIDTH-1:0] head_dest;
  logic [XW-1:0]         dest_x;
  logic [YW-1:0]         dest_y;
  port_e                 head_port;
  logic                  head_loop;

  // Output FSM and registers
  out_state_e            state_reg;
  out_state_e            state_next;
  logic                  load_out;
  logic                  loop_pop;
  logic [PW-1:0]         xbar_data_reg;
  port_e                 port_reg;
  logic                  eject_valid_reg;
  logic [PW-1:0]         eject_data_reg;
  logic [7:0]            err_cnt_reg;

  assign o_ready_to_pe = !fifo_full;
  assign pe_accept     = i_valid_from_pe && o_ready_to_pe;
  assign src_ok        = (i_data_from_pe[SRC_LSB +: ADDR_WIDTH] == NODE_ADDR);
  assign fifo_push     = pe_accept && src_ok;

  noc_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (i_data_from_pe),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Dimension-ordered route: resolve X first, then Y; equal in both means
  // the packet is for our own PE.
  assign head_dest = fifo_head[DEST_LSB +: ADDR_WIDTH];
  assign dest_x    = head_dest[XW-1:0];
  assign dest_y    = head_dest[ADDR_WIDTH-1 -: YW];

  always_comb begin
    head_port = PORT_XP;
    head_loop = 1'b0;
    if (dest_x > LOCAL_X) begin
      head_port = PORT_XP;
    end else if (dest_x < LOCAL_X) begin
      head_port = PORT_XM;
    end else if (dest_y > LOCAL_Y) begin
      head_port = PORT_YP;
    end else if (dest_y < LOCAL_Y) begin
      head_port = PORT_YM;
    end else begin
      head_loop = 1'b1;
    end
  end

  // A loopback head is only taken in IDLE when the network is not using the
  // ejection register; either kind of head blocks the entries behind it.
  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    fifo_pop   = 1'b0;
    loop_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (!head_loop) begin
            state_next = ST_SEND;
            load_out   = 1'b1;
          end else if (!i_valid_from_net) begin
            fifo_pop = 1'b1;
            loop_pop = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // The head stays in the FIFO until the crossbar takes it.
        if (i_ready_from_xbar) begin
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      xbar_data_reg   <= '0;
      port_reg        <= PORT_XP;
      eject_valid_reg <= 1'b0;
      eject_data_reg  <= '0;
      err_cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (load_out) begin
        xbar_data_reg <= fifo_head;
        port_reg      <= head_port;
      end
      eject_valid_reg <= i_valid_from_net || loop_pop;
      if (i_valid_from_net) begin
        eject_data_reg <= i_data_from_net;
      end else if (loop_pop) begin
        eject_data_reg <= fifo_head;
      end
      if (pe_accept && !src_ok && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign o_valid_to_xbar = (state_reg == ST_SEND);
  assign o_data_to_xbar  = xbar_data_reg;
  assign o_port_sel      = port_reg;
  assign o_valid_to_pe   = eject_valid_reg;
  assign o_data_to_pe    = eject_data_reg;
  assign o_err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_router_local_port.sv
// ---------------------------------------------------------------------------
// tb_router_local_port
// Directed bench for router_local_port (NODE_ADDR = 01). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_router_local_port;

  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid_from_pe;
  logic [PW-1:0] i_data_from_pe;
  logic          o_ready_to_pe;
  logic          o_valid_to_pe;
  logic [PW-1:0] o_data_to_pe;
  logic          i_valid_from_net;
  logic [PW-1:0] i_data_from_net;
  logic          o_valid_to_xbar;
  logic [PW-1:0] o_data_to_xbar;
  logic [1:0]    o_port_sel;
  logic          i_ready_from_xbar;
  logic [7:0]    o_err_cnt;

  int checks   = 0;
  int failures = 0;
  int got;
  logic [PW-1:0] exp_q [4];

  always #5 clk = ~clk;

  router_local_port dut (
    .clk               (clk),
    .rst               (rst),
    .i_valid_from_pe   (i_valid_from_pe),
    .i_data_from_pe    (i_data_from_pe),
    .o_ready_to_pe     (o_ready_to_pe),
    .o_valid_to_pe     (o_valid_to_pe),
    .o_data_to_pe      (o_data_to_pe),
    .i_valid_from_net  (i_valid_from_net),
    .i_data_from_net   (i_data_from_net),
    .o_valid_to_xbar   (o_valid_to_xbar),
    .o_data_to_xbar    (o_data_to_xbar),
    .o_port_sel        (o_port_sel),
    .i_ready_from_xbar (i_ready_from_xbar),
    .o_err_cnt         (o_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b0;
    i_valid_from_pe   = 1'b0;
    i_data_from_pe    = '0;
    i_valid_from_net  = 1'b0;
    i_data_from_net   = '0;
    i_ready_from_xbar = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_valid_xbar", o_valid_to_xbar, 0);
    check("rst_valid_pe",   o_valid_to_pe,   0);
    check("rst_data_xbar",  o_data_to_xbar,  0);
    check("rst_data_pe",    o_data_to_pe,    0);
    check("rst_port_sel",   o_port_sel,      0);
    check("rst_err_cnt",    o_err_cnt,       0);
    rst = 1'b1;
    tick();
    check("rst_ready_after_release", o_ready_to_pe, 1);
    $display("reset released: ready=%0b", o_ready_to_pe);

    // ---------------- test 1: X- route, latency 2 ----------------
    i_valid_from_pe = 1'b1;
    i_data_from_pe  = 20'h65A5A;
    tick();                                   // edge N: accepted
    i_valid_from_pe = 1'b0;
    check("t1_not_yet_valid", o_valid_to_xbar, 0);
    tick();                                   // edge N+1: IDLE->SEND
    check("t1_valid", o_valid_to_xbar, 1);
    check("t1_port",  o_port_sel,      1);
    check("t1_data",  o_data_to_xbar,  20'h65A5A);
    $display("t1: port=%0d data=%05h", o_port_sel, o_data_to_xbar);
    i_ready_from_xbar = 1'b1;
    tick();                                   // handshake, pop
    check("t1_done", o_valid_to_xbar, 0);

    // Y+ route: dest 11 from node 01
    i_valid_from_pe = 1'b1;
    i_data_from_pe  = 20'h71234;
    tick();
    i_valid_from_pe = 1'b0;
    tick();
    check("t1b_valid", o_valid_to_xbar, 1);
    check("t1b_port",  o_port_sel,      2);
    check("t1b_data",  o_data_to_xbar,  20'h71234);
    $display("t1b: port=%0d data=%05h", o_port_sel, o_data_to_xbar);
    tick();
    check("t1b_done", o_valid_to_xbar, 0);
    i_ready_from_xbar = 1'b0;

    // ---------------- test 2: loopback ----------------
    i_valid_from_pe = 1'b1;
    i_data_from_pe  = 20'h5A5A5;
    tick();
    i_valid_from_pe = 1'b0;
    check("t2_no_eject_yet", o_valid_to_pe, 0);
    tick();
    check("t2_eject_valid", o_valid_to_pe,   1);
    check("t2_eject_data",  o_data_to_pe,    20'h5A5A5);
    check("t2_no_xbar",     o_valid_to_xbar, 0);
    $display("t2: eject valid=%0b data=%05h", o_valid_to_pe, o_data_to_pe);
    tick();
    check("t2_pulse_end", o_valid_to_pe,   0);
    check("t2_no_xbar2",  o_valid_to_xbar, 0);

    // ---------------- test 5: network priority over loopback ----------------
    i_valid_from_pe  = 1'b1;
    i_data_from_pe   = 20'h50001;
    i_valid_from_net = 1'b1;
    i_data_from_net  = 20'hA1111;
    tick();
    i_valid_from_pe = 1'b0;
    i_data_from_net = 20'hA2222;
    check("t5_net1_valid", o_valid_to_pe, 1);
    check("t5_net1_data",  o_data_to_pe,  20'hA1111);
    tick();
    i_data_from_net = 20'hA3333;
    check("t5_net2_valid", o_valid_to_pe, 1);
    check("t5_net2_data",  o_data_to_pe,  20'hA2222);
    tick();
    i_valid_from_net = 1'b0;
    check("t5_net3_valid", o_valid_to_pe, 1);
    check("t5_net3_data",  o_data_to_pe,  20'hA3333);
    tick();
    check("t5_loop_valid", o_valid_to_pe, 1);
    check("t5_loop_data",  o_data_to_pe,  20'h50001);
    $display("t5: fourth eject data=%05h", o_data_to_pe);
    tick();
    check("t5_pulse_end", o_valid_to_pe, 0);

    // ---------------- test 3: backpressure and ordering ----------------
    exp_q[0] = 20'h60001;
    exp_q[1] = 20'h60002;
    exp_q[2] = 20'h60003;
    exp_q[3] = 20'h60004;
    i_valid_from_pe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data_from_pe = exp_q[k];
      check($sformatf("t3_ready_%0d", k), o_ready_to_pe, 1);
      tick();
    end
    i_data_from_pe = 20'h60005;
    check("t3_full", o_ready_to_pe, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("t3_hold_ready_%0d", k), o_ready_to_pe,   0);
      check($sformatf("t3_hold_valid_%0d", k), o_valid_to_xbar, 1);
      check($sformatf("t3_hold_data_%0d", k),  o_data_to_xbar,  20'h60001);
      check($sformatf("t3_hold_port_%0d", k),  o_port_sel,      1);
    end
    i_valid_from_pe   = 1'b0;
    i_ready_from_xbar = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (o_valid_to_xbar) begin
        check($sformatf("t3_drain_%0d", got), o_data_to_xbar, exp_q[got]);
        $display("t3: drained %0d data=%05h", got, o_data_to_xbar);
        got++;
      end
      tick();
    end
    check("t3_drain_count", got, 4);
    tick();
    check("t3_no_extra",  o_valid_to_xbar, 0);
    check("t3_ready_back", o_ready_to_pe,  1);
    i_ready_from_xbar = 1'b0;

    // ---------------- test 4: bad source drop and saturation ----------------
    i_valid_from_pe = 1'b1;
    i_data_from_pe  = 20'h25A5A;
    tick();
    check("t4_err_1", o_err_cnt, 1);
    for (int k = 0; k < 253; k++) tick();
    check("t4_err_254", o_err_cnt, 254);
    tick();
    check("t4_err_255", o_err_cnt, 255);
    for (int k = 0; k < 45; k++) tick();
    check("t4_err_sat", o_err_cnt, 255);
    $display("t4: err_cnt after 300 drops=%0d", o_err_cnt);
    i_valid_from_pe = 1'b0;
    tick();
    check("t4_not_queued", o_valid_to_xbar, 0);
    check("t4_ready",      o_ready_to_pe,   1);

    // ---------------- test 6: reset in SEND ----------------
    i_valid_from_pe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data_from_pe = 20'h60011 + k;
      tick();
    end
    i_valid_from_pe = 1'b0;
    check("t6_in_send", o_valid_to_xbar, 1);
    check("t6_head",    o_data_to_xbar,  20'h60011);
    rst = 1'b0;
    #1;
    check("t6_rst_valid_xbar", o_valid_to_xbar, 0);
    check("t6_rst_data_xbar",  o_data_to_xbar,  0);
    check("t6_rst_port",       o_port_sel,      0);
    check("t6_rst_err",        o_err_cnt,       0);
    check("t6_rst_valid_pe",   o_valid_to_pe,   0);
    check("t6_rst_ready",      o_ready_to_pe,   1);
    $display("t6: async reset valid_xbar=%0b err=%0d", o_valid_to_xbar, o_err_cnt);
    tick();
    tick();
    rst = 1'b1;
    i_ready_from_xbar = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6_quiet_xbar_%0d", k), o_valid_to_xbar, 0);
      check($sformatf("t6_quiet_pe_%0d", k),   o_valid_to_pe,   0);
    end
    check("t6_ready_after", o_ready_to_pe, 1);
    // Port still functional after the reset.
    i_valid_from_pe = 1'b1;
    i_data_from_pe  = 20'h65A5A;
    tick();
    i_valid_from_pe = 1'b0;
    tick();
    check("t6_resume_valid", o_valid_to_xbar, 1);
    check("t6_resume_data",  o_data_to_xbar,  20'h65A5A);
    tick();
    check("t6_resume_done",  o_valid_to_xbar, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
